// File: rtl/matrix_mem_pkg.sv
// Shared constants and types for the matrix main memory block: bus select IDs,
// controller states and the preload image used when MATRIX_MEM_PRELOAD_EN is defined.
package matrix_mem_pkg;

  localparam logic [3:0] MainMemEn  = 4'd0;
  localparam logic [3:0] RegisterEn = 4'd1;
  localparam logic [3:0] InstrMemEn = 4'd2;
  localparam logic [3:0] AluEn      = 4'd3;
  localparam logic [3:0] ExecuteEn  = 4'd4;
  localparam logic [3:0] IntAlu     = 4'd5;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_t;

  localparam int unsigned PRELOAD_WORDS = 10;

  localparam logic [255:0] PRELOAD [PRELOAD_WORDS] = '{
    256'h0003_0002_0008_0006_000c_0006_0003_0009_0009_000c_0002_000d_000c_000e_0010_0003,
    256'h0006_0004_0007_000f_0007_000a_0004_0007_0004_0003_0005_0008_000c_0005_0002_0006,
    256'h0,
    256'h0,
    256'h0,
    256'h0,
    256'h0,
    256'h0,
    256'h04,
    256'h11
  };

  function automatic logic [255:0] preload_word(input int unsigned idx);
    if (idx < PRELOAD_WORDS) return PRELOAD[idx];
    return '0;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response pipeline: RD_LAT stages of valid/error/data with synchronous flush.
module mem_rd_pipe #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] valid;
  logic [RD_LAT-1:0] err;
  logic [DATA_W-1:0] data [RD_LAT];

  // Data only advances behind a valid token so the output holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      err   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) data[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      err[0]   <= in_valid & in_err;
      if (in_valid) data[0] <= in_data;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid[i] <= valid[i-1];
        err[i]   <= err[i-1];
        if (valid[i-1]) data[i] <= data[i-1];
      end
    end
  end

  assign out_valid = valid[RD_LAT-1];
  assign out_err   = err[RD_LAT-1];
  assign out_data  = data[RD_LAT-1];

endmodule

// File: rtl/matrix_main_memory.sv
// Matrix main memory: DEPTH words with per-lane write masking, pipelined reads and a
// post-reset clear sequence. Defining MATRIX_MEM_PRELOAD_EN clears to the preload image.
module matrix_main_memory
  import matrix_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DEPTH  = 14,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned SEL_ID = 0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     ReqValid,
  input  logic                     ReqWrite,
  input  logic [15:0]              Address,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [DATA_W/ELEM_W-1:0] LaneMask,
  output logic                     ReqReady,
  output logic                     RspValid,
  output logic [DATA_W-1:0]        RdData,
  output logic                     AddrErr
);

  localparam int unsigned LANES = DATA_W / ELEM_W;
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t        state;
  logic [IW-1:0]     clr_idx;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] rd_word;
  logic              sel;
  logic              in_range;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic              clearing;
  logic              unused_addr;

  assign unused_addr = ^Address[11:8];

  // The range check uses all of Address[7:0], not only the index bits.
  assign sel      = (Address[15:12] == 4'(SEL_ID));
  assign in_range = ({24'd0, Address[7:0]} < DEPTH);
  assign idx      = Address[IW-1:0];
  assign accept   = ReqValid & ReqReady & sel & ~Reset;
  assign wr_en    = accept & ReqWrite & in_range;
  assign rd_en    = accept & ~ReqWrite;
  assign clearing = (state == CLEAR) & ~Reset;

`ifdef MATRIX_MEM_PRELOAD_EN
  assign init_word = DATA_W'(preload_word(32'(clr_idx)));
`else
  assign init_word = '0;
`endif

  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[idx];
  end

  always_ff @(posedge Clk) begin
    if (clearing) begin
      mem[clr_idx] <= init_word;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (LaneMask[i]) mem[idx][ELEM_W*i +: ELEM_W] <= WrData[ELEM_W*i +: ELEM_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      ReqReady <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == IW'(DEPTH - 1)) begin
            state    <= READY;
            ReqReady <= 1'b1;
          end else begin
            clr_idx <= clr_idx + IW'(1);
          end
        end
        READY: ReqReady <= 1'b1;
        default: begin
          state    <= CLEAR;
          clr_idx  <= '0;
          ReqReady <= 1'b0;
        end
      endcase
    end
  end

  mem_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk      (Clk),
    .reset    (Reset),
    .in_valid (rd_en),
    .in_err   (~in_range),
    .in_data  (rd_word),
    .out_valid(RspValid),
    .out_err  (AddrErr),
    .out_data (RdData)
  );

endmodule
